// File: rtl/ram_arbiter_if.sv
// Request-side bundle for one ram_arbiter port: valid/ready handshake,
// write/lock qualifiers, address/write data, and the read-return pair.
interface ram_arbiter_if #(
    parameter int unsigned addr_bits  = 16,
    parameter int unsigned data_width = 8
);
    logic                  valid;
    logic                  write;
    logic                  lock;
    logic [addr_bits-1:0]  address;
    logic [data_width-1:0] wdata;
    logic                  ready;
    logic                  rvalid;
    logic [data_width-1:0] rdata;

    modport master (
        output valid, write, lock, address, wdata,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, write, lock, address, wdata,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM (1-cycle registered read)
// between requester port 0 (CPU data) and port 1 (fetch/loader).
// Round-robin arbitration in IDLE; a lock keeps the RAM with one port for RMW.
// Build option: RAM_ARB_FIXED_PRIORITY_EN makes port 0 win every IDLE contest
// (last_grant is still tracked but does not affect the grant).
module ram_arbiter #(
    parameter int unsigned addr_bits  = 16,
    parameter int unsigned data_width = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    ram_arbiter_if.slave          req0,
    ram_arbiter_if.slave          req1,
    output logic                  ram_write_enable,
    output logic [addr_bits-1:0]  ram_address,
    output logic [data_width-1:0] ram_data_in,
    input  logic [data_width-1:0] ram_data_out
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t state;
    state_t state_next;

    logic       last_grant;
    logic       lock_owner;
    logic [1:0] rvalid_q;

    logic       grant_valid;
    logic       grant_port;
    logic       sel_write;
    logic       sel_lock;

    // State register; reset drops any held lock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection and next state; nothing is granted while reset is low.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        state_next  = state;
        case (state)
            IDLE: begin
                if (req0.valid && req1.valid) begin
                    grant_valid = 1'b1;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
                    grant_port  = 1'b0;
`else
                    grant_port  = ~last_grant;
`endif
                end else if (req0.valid) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b0;
                end else if (req1.valid) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b1;
                end
            end
            LOCKED: begin
                grant_port  = lock_owner;
                grant_valid = lock_owner ? req1.valid : req0.valid;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!reset_n) begin
            grant_valid = 1'b0;
        end
        if (grant_valid) begin
            state_next = (grant_port ? req1.lock : req0.lock) ? LOCKED : IDLE;
        end
    end

    // Request fields of the granted port (port 0 when nothing is granted in IDLE).
    assign sel_write        = grant_port ? req1.write : req0.write;
    assign sel_lock         = grant_port ? req1.lock  : req0.lock;
    assign ram_address      = grant_port ? req1.address : req0.address;
    assign ram_data_in      = grant_port ? req1.wdata   : req0.wdata;
    assign ram_write_enable = grant_valid & sel_write;

    assign req0.ready  = grant_valid & ~grant_port;
    assign req1.ready  = grant_valid &  grant_port;
    assign req0.rvalid = rvalid_q[0];
    assign req1.rvalid = rvalid_q[1];
    assign req0.rdata  = ram_data_out;
    assign req1.rdata  = ram_data_out;

    // Fairness pointer, lock owner and one-cycle read-return flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            lock_owner <= 1'b0;
            rvalid_q   <= '0;
        end else begin
            rvalid_q <= '0;
            if (grant_valid) begin
                last_grant <= grant_port;
                if (!sel_write) begin
                    rvalid_q[grant_port] <= 1'b1;
                end
                if (sel_lock) begin
                    lock_owner <= grant_port;
                end
            end
        end
    end

endmodule
